// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver, majority vote, valid/ready output.
// Optional parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 4800,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_S0   = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(CPB / 2);
    localparam logic [TW-1:0] T_VOTE = TW'(CPB / 2 + 1);
    localparam logic [TW-1:0] T_WRAP = TW'(CPB - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS);

    if (CPB < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_rx_cfg: illegal parameter set");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic                 ferr_q, ferr_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 ovr_q, ovr_d;
    logic                 perr_q, perr_d;
    logic                 rxs, vote, at_vote, at_wrap, last_stop;
    logic                 deliver, fe_new;

    assign rxs       = sync_q[1];
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) |
                       (samp_q[1] & rxs);
    assign at_vote   = (tick_q == T_VOTE);
    assign at_wrap   = (tick_q == T_WRAP);
    assign last_stop = (STOP_BITS == 1) || stop_q;
    assign fe_new    = ferr_q | ~vote;

    // Two-flop synchronizer for the asynchronous line, idles high.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rxd};
    end

    // State, datapath and holding-register flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            samp_q  <= '0;
            ferr_q  <= 1'b0;
            stop_q  <= 1'b0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
            ferr_q  <= ferr_d;
            stop_q  <= stop_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame FSM: bit timing, voting, payload assembly, delivery request.
    always_comb begin
        state_d = state_q;
        tick_d  = at_wrap ? '0 : tick_q + 1'b1;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        ferr_d  = ferr_q;
        stop_d  = stop_q;
        perr_d  = perr_q;
        deliver = 1'b0;
        if (tick_q == T_S0) samp_d[0] = rxs;
        if (tick_q == T_S1) samp_d[1] = rxs;
        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                    bcnt_d  = '0;
                    ferr_d  = 1'b0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (at_vote && vote) state_d = S_IDLE;
                else if (at_wrap)    state_d = S_DATA;
            end
            S_DATA: begin
                if (at_vote) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (MSB_FIRST != 0)
                        shift_d = {shift_q[DATA_BITS-2:0], vote};
                    else
                        shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (at_wrap && bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (at_vote)
                    perr_d = vote ^ (^shift_q) ^ 1'(PARITY_ODD);
                if (at_wrap) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (at_vote) begin
                    if (!vote) ferr_d = 1'b0 | 1'b1;
                    if (last_stop) begin
                        deliver = 1'b1;
                        state_d = vote ? S_IDLE : S_WAIT_HIGH;
                    end
                end else if (at_wrap) begin
                    stop_d = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                tick_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Single-entry holding register with overrun tracking.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        ovr_d   = ovr_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
                fe_d    = fe_new;
                pe_d    = perr_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
